// File: rtl/kamacore_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kamacore_pkg
//  Description : Shared widths, ALU opcodes, ID/EX state encoding and the
//                packed control bundle carried down the kamacore pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
package kamacore_pkg;

    localparam int DATA_WIDTH     = 16;
    localparam int REG_ADDR_WIDTH = 4;
    localparam int ALU_OP_WIDTH   = 4;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_AND = 4'h2,
        ALU_OR  = 4'h3,
        ALU_XOR = 4'h4,
        ALU_SHL = 4'h5,
        ALU_SHR = 4'h6,
        ALU_SLT = 4'h7
    } alu_op_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        HOLD   = 2'd2
    } id_ex_state_t;

    typedef struct packed {
        logic write_register;
        logic mem_read;
        logic mem_write;
    } id_ex_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/kamacore_id_ex_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : kamacore_id_ex_stage_if
//  Description : ID-side inputs, ID_stall and EX-side outputs of the ID/EX
//                pipeline register. The slave modport is the stage's view;
//                the master modport is the surrounding pipeline's view.
//  Revision    : 1.0  initial release
// ============================================================================
interface kamacore_id_ex_stage_if;

    logic                                     ID_valid;
    logic [kamacore_pkg::REG_ADDR_WIDTH-1:0]  ID_register_a;
    logic [kamacore_pkg::REG_ADDR_WIDTH-1:0]  ID_register_b;
    logic                                     ID_uses_a;
    logic                                     ID_uses_b;
    logic [kamacore_pkg::DATA_WIDTH-1:0]      ID_forwarded_data_a;
    logic [kamacore_pkg::DATA_WIDTH-1:0]      ID_forwarded_data_b;
    logic [kamacore_pkg::DATA_WIDTH-1:0]      ID_immediate;
    logic [kamacore_pkg::ALU_OP_WIDTH-1:0]    ID_alu_op;
    logic [kamacore_pkg::REG_ADDR_WIDTH-1:0]  ID_destination_register;
    logic                                     ID_control_write_register;
    logic                                     ID_control_mem_read;
    logic                                     ID_control_mem_write;
    logic                                     ID_stall;

    logic                                     EX_valid;
    logic [kamacore_pkg::REG_ADDR_WIDTH-1:0]  EX_register_a;
    logic [kamacore_pkg::REG_ADDR_WIDTH-1:0]  EX_register_b;
    logic [kamacore_pkg::DATA_WIDTH-1:0]      EX_data_a;
    logic [kamacore_pkg::DATA_WIDTH-1:0]      EX_data_b;
    logic [kamacore_pkg::DATA_WIDTH-1:0]      EX_immediate;
    logic [kamacore_pkg::ALU_OP_WIDTH-1:0]    EX_alu_op;
    logic [kamacore_pkg::REG_ADDR_WIDTH-1:0]  EX_destination_register;
    logic                                     EX_control_write_register;
    logic                                     EX_control_mem_read;
    logic                                     EX_control_mem_write;

    modport slave (
        input  ID_valid, ID_register_a, ID_register_b, ID_uses_a, ID_uses_b,
               ID_forwarded_data_a, ID_forwarded_data_b, ID_immediate,
               ID_alu_op, ID_destination_register, ID_control_write_register,
               ID_control_mem_read, ID_control_mem_write,
        output ID_stall,
               EX_valid, EX_register_a, EX_register_b, EX_data_a, EX_data_b,
               EX_immediate, EX_alu_op, EX_destination_register,
               EX_control_write_register, EX_control_mem_read,
               EX_control_mem_write
    );

    modport master (
        output ID_valid, ID_register_a, ID_register_b, ID_uses_a, ID_uses_b,
               ID_forwarded_data_a, ID_forwarded_data_b, ID_immediate,
               ID_alu_op, ID_destination_register, ID_control_write_register,
               ID_control_mem_read, ID_control_mem_write,
        input  ID_stall,
               EX_valid, EX_register_a, EX_register_b, EX_data_a, EX_data_b,
               EX_immediate, EX_alu_op, EX_destination_register,
               EX_control_write_register, EX_control_mem_read,
               EX_control_mem_write
    );

endinterface
`default_nettype wire

// File: rtl/kamacore_load_use_detect.sv
`default_nettype none
// ============================================================================
//  Module      : kamacore_load_use_detect
//  Description : Combinational load-use compare. Flags an ID instruction that
//                reads the destination of a load still sitting in EX.
//                r0 is hard-wired zero, so it never creates a dependency.
//  Ports       : i_ex_*  - load currently in EX
//                i_id_*  - instruction currently in ID
//                o_load_use - bubble required
//  Revision    : 1.0  initial release
// ============================================================================
module kamacore_load_use_detect
    import kamacore_pkg::*;
(
    input  wire                       i_ex_valid,
    input  wire                       i_ex_mem_read,
    input  wire [REG_ADDR_WIDTH-1:0]  i_ex_dest,
    input  wire                       i_id_valid,
    input  wire                       i_id_uses_a,
    input  wire                       i_id_uses_b,
    input  wire [REG_ADDR_WIDTH-1:0]  i_id_reg_a,
    input  wire [REG_ADDR_WIDTH-1:0]  i_id_reg_b,
    output logic                      o_load_use
);

    logic w_ex_is_load;
    logic w_hit_a;
    logic w_hit_b;

    assign w_ex_is_load = i_ex_valid && i_ex_mem_read && (i_ex_dest != '0);
    assign w_hit_a      = i_id_uses_a && (i_id_reg_a == i_ex_dest);
    assign w_hit_b      = i_id_uses_b && (i_id_reg_b == i_ex_dest);
    assign o_load_use   = w_ex_is_load && i_id_valid && (w_hit_a || w_hit_b);

endmodule
`default_nettype wire

// File: rtl/kamacore_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : kamacore_id_ex_stage
//  Description : ID/EX pipeline register with built-in load-use interlock.
//                Priority each cycle: flush > mem_busy > load_use > advance.
//  Ports       : clk, reset (async, active-high), flush, mem_busy
//                bus       - kamacore_id_ex_stage_if.slave (ID_*, ID_stall,
//                            EX_*)
//                stall_count / bubble_count - only when
//                            KAMACORE_HAZARD_STATS_EN is defined
//  Revision    : 1.0  initial release
// ============================================================================
module kamacore_id_ex_stage
    import kamacore_pkg::*;
(
    input  wire                    clk,
    input  wire                    reset,
    input  wire                    flush,
    input  wire                    mem_busy,
    kamacore_id_ex_stage_if.slave  bus
`ifdef KAMACORE_HAZARD_STATS_EN
    ,
    output logic [15:0]            stall_count,
    output logic [15:0]            bubble_count
`endif
);

    id_ex_state_t               r_state;
    logic                       r_ex_valid;
    logic [REG_ADDR_WIDTH-1:0]  r_ex_reg_a;
    logic [REG_ADDR_WIDTH-1:0]  r_ex_reg_b;
    logic [DATA_WIDTH-1:0]      r_ex_data_a;
    logic [DATA_WIDTH-1:0]      r_ex_data_b;
    logic [DATA_WIDTH-1:0]      r_ex_imm;
    logic [ALU_OP_WIDTH-1:0]    r_ex_alu_op;
    logic [REG_ADDR_WIDTH-1:0]  r_ex_dest;
    id_ex_ctrl_t                r_ex_ctrl;

    logic                       w_load_use;
    logic                       w_stall;
    id_ex_ctrl_t                w_id_ctrl;

    kamacore_load_use_detect u_load_use_detect (
        .i_ex_valid    (r_ex_valid),
        .i_ex_mem_read (r_ex_ctrl.mem_read),
        .i_ex_dest     (r_ex_dest),
        .i_id_valid    (bus.ID_valid),
        .i_id_uses_a   (bus.ID_uses_a),
        .i_id_uses_b   (bus.ID_uses_b),
        .i_id_reg_a    (bus.ID_register_a),
        .i_id_reg_b    (bus.ID_register_b),
        .o_load_use    (w_load_use)
    );

    // A flush discards whatever ID holds, so there is nothing to stall for.
    assign w_stall = !flush && (mem_busy || w_load_use);

    // Invalid ID slots must never carry live side effects into EX.
    assign w_id_ctrl = bus.ID_valid ? id_ex_ctrl_t'{bus.ID_control_write_register,
                                                    bus.ID_control_mem_read,
                                                    bus.ID_control_mem_write}
                                    : id_ex_ctrl_t'('0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= RUN;
            r_ex_valid  <= 1'b0;
            r_ex_reg_a  <= '0;
            r_ex_reg_b  <= '0;
            r_ex_data_a <= '0;
            r_ex_data_b <= '0;
            r_ex_imm    <= '0;
            r_ex_alu_op <= '0;
            r_ex_dest   <= '0;
            r_ex_ctrl   <= '0;
        end else if (flush) begin
            // Data fields are left as-is; they are meaningless once invalid.
            r_state    <= RUN;
            r_ex_valid <= 1'b0;
            r_ex_ctrl  <= '0;
        end else if (mem_busy) begin
            r_state <= HOLD;
        end else if (w_load_use) begin
            // Bubble: kill the slot but keep data so the load result path
            // is undisturbed; ID re-presents the same instruction next cycle.
            r_state    <= BUBBLE;
            r_ex_valid <= 1'b0;
            r_ex_ctrl  <= '0;
        end else begin
            r_state     <= RUN;
            r_ex_valid  <= bus.ID_valid;
            r_ex_reg_a  <= bus.ID_register_a;
            r_ex_reg_b  <= bus.ID_register_b;
            r_ex_data_a <= bus.ID_forwarded_data_a;
            r_ex_data_b <= bus.ID_forwarded_data_b;
            r_ex_imm    <= bus.ID_immediate;
            r_ex_alu_op <= bus.ID_alu_op;
            r_ex_dest   <= bus.ID_destination_register;
            r_ex_ctrl   <= w_id_ctrl;
        end
    end

`ifndef SYNTHESIS
    // The bubble empties EX, so the same pair cannot hazard twice.
    always @(posedge clk) begin
        if (!reset && r_state == BUBBLE) begin
            a_no_rebubble: assert (!w_load_use);
        end
    end
`endif

`ifdef KAMACORE_HAZARD_STATS_EN
    logic [15:0] r_stall_count;
    logic [15:0] r_bubble_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count  <= '0;
            r_bubble_count <= '0;
        end else begin
            if (w_stall && r_stall_count != 16'hFFFF) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
            // BUBBLE lasts one cycle, so every taken bubble is a fresh entry.
            if (!flush && !mem_busy && w_load_use && r_bubble_count != 16'hFFFF) begin
                r_bubble_count <= r_bubble_count + 16'd1;
            end
        end
    end

    assign stall_count  = r_stall_count;
    assign bubble_count = r_bubble_count;
`endif

    assign bus.ID_stall                  = w_stall;
    assign bus.EX_valid                  = r_ex_valid;
    assign bus.EX_register_a             = r_ex_reg_a;
    assign bus.EX_register_b             = r_ex_reg_b;
    assign bus.EX_data_a                 = r_ex_data_a;
    assign bus.EX_data_b                 = r_ex_data_b;
    assign bus.EX_immediate              = r_ex_imm;
    assign bus.EX_alu_op                 = r_ex_alu_op;
    assign bus.EX_destination_register   = r_ex_dest;
    assign bus.EX_control_write_register = r_ex_ctrl.write_register;
    assign bus.EX_control_mem_read       = r_ex_ctrl.mem_read;
    assign bus.EX_control_mem_write      = r_ex_ctrl.mem_write;

endmodule
`default_nettype wire

// File: tb/tb_kamacore_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kamacore_id_ex_stage
//  Description : Directed bench for the ID/EX stage with a behavioural model
//                of the EX slot and literal checkpoints.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_kamacore_id_ex_stage;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic mem_busy = 1'b0;

    always #5 clk = ~clk;

    kamacore_id_ex_stage_if bus();

`ifdef KAMACORE_HAZARD_STATS_EN
    logic [15:0] stall_count;
    logic [15:0] bubble_count;
`endif

    kamacore_id_ex_stage dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .mem_busy (mem_busy),
        .bus      (bus)
`ifdef KAMACORE_HAZARD_STATS_EN
        ,
        .stall_count  (stall_count),
        .bubble_count (bubble_count)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model of the instruction sitting in EX.
    bit        m_v, m_w, m_mr, m_mw, m_known;
    bit [3:0]  m_ra, m_rb, m_op, m_dest;
    bit [15:0] m_da, m_db, m_imm;
    int        m_sc, m_bc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ID wants a register that the load in EX has not produced yet.
    function automatic bit model_hazard();
        bit reads_it;
        reads_it = (bus.ID_uses_a && bus.ID_register_a == m_dest) ||
                   (bus.ID_uses_b && bus.ID_register_b == m_dest);
        return m_v && m_mr && (m_dest != 4'd0) && bus.ID_valid && reads_it;
    endfunction

    function automatic bit model_stall();
        return !flush && (mem_busy || model_hazard());
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            {m_v, m_w, m_mr, m_mw} = '0;
            {m_ra, m_rb, m_op, m_dest} = '0;
            {m_da, m_db, m_imm} = '0;
            m_known = 1'b1;
            m_sc = 0;
            m_bc = 0;
        end else begin
            if (model_stall() && m_sc < 65535) m_sc++;
            if (flush) begin
                {m_v, m_w, m_mr, m_mw} = '0;
                m_known = 1'b0;
            end else if (mem_busy) begin
                // slot frozen
            end else if (model_hazard()) begin
                {m_v, m_w, m_mr, m_mw} = '0;
                if (m_bc < 65535) m_bc++;
            end else begin
                m_v    = bus.ID_valid;
                m_w    = bus.ID_valid & bus.ID_control_write_register;
                m_mr   = bus.ID_valid & bus.ID_control_mem_read;
                m_mw   = bus.ID_valid & bus.ID_control_mem_write;
                m_ra   = bus.ID_register_a;
                m_rb   = bus.ID_register_b;
                m_da   = bus.ID_forwarded_data_a;
                m_db   = bus.ID_forwarded_data_b;
                m_imm  = bus.ID_immediate;
                m_op   = bus.ID_alu_op;
                m_dest = bus.ID_destination_register;
                m_known = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_ex_valid", 32'(bus.EX_valid), 32'(m_v));
            chk("m_ex_wr", 32'(bus.EX_control_write_register), 32'(m_w));
            chk("m_ex_mr", 32'(bus.EX_control_mem_read), 32'(m_mr));
            chk("m_ex_mw", 32'(bus.EX_control_mem_write), 32'(m_mw));
            chk("m_id_stall", 32'(bus.ID_stall), 32'(model_stall()));
            if (m_known) begin
                chk("m_ex_ra", 32'(bus.EX_register_a), 32'(m_ra));
                chk("m_ex_rb", 32'(bus.EX_register_b), 32'(m_rb));
                chk("m_ex_da", 32'(bus.EX_data_a), 32'(m_da));
                chk("m_ex_db", 32'(bus.EX_data_b), 32'(m_db));
                chk("m_ex_imm", 32'(bus.EX_immediate), 32'(m_imm));
                chk("m_ex_op", 32'(bus.EX_alu_op), 32'(m_op));
                chk("m_ex_dest", 32'(bus.EX_destination_register), 32'(m_dest));
            end
`ifdef KAMACORE_HAZARD_STATS_EN
            chk("m_stall_count", 32'(stall_count), 32'(m_sc));
            chk("m_bubble_count", 32'(bubble_count), 32'(m_bc));
`endif
        end
    end

    task automatic drive(input bit v, input bit [3:0] ra, input bit [3:0] rb,
                         input bit ua, input bit ub, input bit [15:0] da,
                         input bit [15:0] db, input bit [15:0] imm,
                         input bit [3:0] op, input bit [3:0] dest,
                         input bit w, input bit mr, input bit mw);
        bus.ID_valid = v;
        bus.ID_register_a = ra;
        bus.ID_register_b = rb;
        bus.ID_uses_a = ua;
        bus.ID_uses_b = ub;
        bus.ID_forwarded_data_a = da;
        bus.ID_forwarded_data_b = db;
        bus.ID_immediate = imm;
        bus.ID_alu_op = op;
        bus.ID_destination_register = dest;
        bus.ID_control_write_register = w;
        bus.ID_control_mem_read = mr;
        bus.ID_control_mem_write = mw;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 0);
        cyc();
        cyc();
        chk("rst_ex_valid", 32'(bus.EX_valid), 32'd0);
        chk("rst_id_stall", 32'(bus.ID_stall), 32'd0);
        chk("rst_ex_data_a", 32'(bus.EX_data_a), 32'd0);
        reset = 1'b0;
        cmp_en = 1'b1;

        // Plain advance: r1=5, r2=3, op 1, dest r3, write.
        drive(1, 1, 2, 1, 1, 16'h0005, 16'h0003, 16'h0010, 4'h1, 3, 1, 0, 0);
        #1 chk("adv_stall", 32'(bus.ID_stall), 32'd0);
        cyc();
        chk("adv_data_a", 32'(bus.EX_data_a), 32'h5);
        chk("adv_data_b", 32'(bus.EX_data_b), 32'h3);
        chk("adv_valid", 32'(bus.EX_valid), 32'd1);
        chk("adv_dest", 32'(bus.EX_destination_register), 32'd3);

        // Load to r4, then a consumer reading r4 on port b.
        drive(1, 1, 0, 1, 0, 16'h0100, 16'h0000, 16'h0004, 4'h0, 4, 1, 1, 0);
        cyc();
        drive(1, 5, 4, 1, 1, 16'h1111, 16'h2222, 16'h0000, 4'h2, 6, 1, 0, 0);
        #1 chk("lu_stall_on", 32'(bus.ID_stall), 32'd1);
        cyc();
        chk("lu_bubble_valid", 32'(bus.EX_valid), 32'd0);
        chk("lu_bubble_mr", 32'(bus.EX_control_mem_read), 32'd0);
        chk("lu_bubble_wr", 32'(bus.EX_control_write_register), 32'd0);
        chk("lu_bubble_data_kept", 32'(bus.EX_data_a), 32'h0100);
        #1 chk("lu_stall_off", 32'(bus.ID_stall), 32'd0);
        cyc();
        chk("lu_capture_valid", 32'(bus.EX_valid), 32'd1);
        chk("lu_capture_db", 32'(bus.EX_data_b), 32'h2222);
        chk("lu_capture_dest", 32'(bus.EX_destination_register), 32'd6);

        // Load with destination r0 never interlocks.
        drive(1, 1, 0, 1, 0, 16'h0200, 16'h0000, 16'h0000, 4'h0, 0, 0, 1, 0);
        cyc();
        drive(1, 0, 0, 1, 1, 16'h0000, 16'h0000, 16'h0000, 4'h3, 2, 1, 0, 0);
        #1 chk("r0_no_stall", 32'(bus.ID_stall), 32'd0);
        cyc();
        chk("r0_valid", 32'(bus.EX_valid), 32'd1);

        // Load to r7; a consumer naming r7 but not reading it, then an invalid one.
        drive(1, 1, 0, 1, 0, 16'h0300, 16'h0000, 16'h0000, 4'h0, 7, 1, 1, 0);
        cyc();
        drive(1, 7, 7, 0, 0, 16'h0777, 16'h0000, 16'h0000, 4'h4, 5, 1, 0, 0);
        #1 chk("nouse_no_stall", 32'(bus.ID_stall), 32'd0);
        cyc();
        drive(1, 1, 0, 1, 0, 16'h0300, 16'h0000, 16'h0000, 4'h0, 7, 1, 1, 0);
        cyc();
        drive(0, 7, 7, 1, 1, 16'h0888, 16'h0999, 16'h0000, 4'h5, 9, 1, 1, 1);
        #1 chk("inv_no_stall", 32'(bus.ID_stall), 32'd0);
        cyc();
        chk("inv_valid", 32'(bus.EX_valid), 32'd0);
        chk("inv_ctrl", 32'({bus.EX_control_write_register, bus.EX_control_mem_read,
                             bus.EX_control_mem_write}), 32'd0);
        chk("inv_reg_a", 32'(bus.EX_register_a), 32'd7);

        // mem_busy for 3 cycles with instruction A in EX.
        drive(1, 1, 2, 1, 1, 16'hAAAA, 16'h0001, 16'h0000, 4'h1, 8, 1, 0, 0);
        cyc();
        drive(1, 3, 4, 1, 1, 16'hBBBB, 16'h0002, 16'h0000, 4'h2, 9, 1, 0, 0);
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("busy_stall", 32'(bus.ID_stall), 32'd1);
            cyc();
            chk("busy_hold_a", 32'(bus.EX_data_a), 32'hAAAA);
        end
        mem_busy = 1'b0;
        #1 chk("busy_release_stall", 32'(bus.ID_stall), 32'd0);
        cyc();
        chk("busy_advance", 32'(bus.EX_data_a), 32'hBBBB);

        // flush with mem_busy and a live load-use all at once.
        drive(1, 1, 0, 1, 0, 16'h0400, 16'h0000, 16'h0000, 4'h0, 9, 1, 1, 0);
        cyc();
        drive(1, 9, 0, 1, 0, 16'h0500, 16'h0000, 16'h0000, 4'h1, 10, 1, 0, 0);
        mem_busy = 1'b1;
        flush = 1'b1;
        #1 chk("flush_stall", 32'(bus.ID_stall), 32'd0);
        cyc();
        chk("flush_valid", 32'(bus.EX_valid), 32'd0);
        chk("flush_mr", 32'(bus.EX_control_mem_read), 32'd0);
        flush = 1'b0;
        mem_busy = 1'b0;
        #1 chk("post_flush_stall", 32'(bus.ID_stall), 32'd0);
        cyc();
        chk("post_flush_capture", 32'(bus.EX_data_a), 32'h0500);

        // Asynchronous reset mid-cycle with EX loaded.
        drive(0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(bus.EX_valid), 32'd0);
        chk("async_rst_data_a", 32'(bus.EX_data_a), 32'd0);
        chk("async_rst_dest", 32'(bus.EX_destination_register), 32'd0);
        chk("async_rst_wr", 32'(bus.EX_control_write_register), 32'd0);
        chk("async_rst_stall", 32'(bus.ID_stall), 32'd0);
        cyc();
        reset = 1'b0;
        cyc();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
